// File: rtl/hpd_ctrl.sv
// Hot-plug-detect controller: debounces the HPD enable, waits for a stable pixel-PLL lock,
// and forces minimum-width low pulses on EDID updates or lock loss.
module hpd_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned ASSERT_DELAY    = 100000,
  parameter int unsigned HPD_LOW_CYCLES  = 10000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pll_locked,
  input  logic       edid_update,
  output logic       hpd_out,
  output logic [1:0] state_o,
  output logic [7:0] replug_count
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ASSERT_DELAY - 1);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(HPD_LOW_CYCLES - 1);
  localparam logic [7:0]       REPLUG_MAX = 8'hFF;

  logic             lock_meta;
  logic             lock_s;
  logic             en_stable;
  logic [CNT_W-1:0] db_cnt;
  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_n;
  logic [7:0]       replug_n;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Enable debounce: a new level must persist DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      en_stable <= 1'b0;
      db_cnt    <= '0;
    end else if (enable != en_stable) begin
      if (db_cnt == DB_LAST) begin
        en_stable <= enable;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_OFF;
      timer        <= '0;
      hpd_out      <= 1'b0;
      replug_count <= '0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      hpd_out      <= (state_n == S_ON);
      replug_count <= replug_n;
    end
  end

  // Next-state logic; the shared timer clears on every state change
  always_comb begin
    state_n  = state;
    timer_n  = '0;
    replug_n = replug_count;
    case (state)
      S_OFF: begin
        if (en_stable) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (!en_stable) begin
          state_n = S_OFF;
        end else if (lock_s) begin
          if (timer == ON_LAST) state_n = S_ON;
          else                  timer_n = timer + CNT_ONE;
        end
      end
      S_ON: begin
        if (!en_stable) begin
          state_n = S_OFF;
        end else if (!lock_s || edid_update) begin
          state_n = S_LOW;
          if (replug_count != REPLUG_MAX) replug_n = replug_count + 8'd1;
        end
      end
      S_LOW: begin
        // Pulse width is fixed; enable and lock are only consulted at expiry
        if (timer == LOW_LAST) state_n = en_stable ? S_WAIT : S_OFF;
        else                   timer_n = timer + CNT_ONE;
      end
      default: state_n = S_OFF;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_hpd_ctrl.sv
// Directed bench for hpd_ctrl with DEBOUNCE_CYCLES=4, ASSERT_DELAY=8, HPD_LOW_CYCLES=16.
module tb_hpd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pll_locked;
  logic       edid_update;
  logic       hpd_out;
  logic [1:0] state_o;
  logic [7:0] replug_count;

  int total = 0;
  int bad   = 0;

  hpd_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .ASSERT_DELAY(8),
    .HPD_LOW_CYCLES(16),
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pll_locked(pll_locked),
    .edid_update(edid_update),
    .hpd_out(hpd_out),
    .state_o(state_o),
    .replug_count(replug_count)
  );

  always #5 clk = ~clk;

  // Advance n active edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; pll_locked = 1'b1; edid_update = 1'b0;
    tick(3);
    total++; if (hpd_out !== 1'b0) begin bad++; $display("FAIL reset_hpd got=%0b exp=0", hpd_out); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (replug_count !== 8'd0) begin bad++; $display("FAIL reset_replug got=%0d exp=0", replug_count); end
  endtask

  // Release reset with enable and lock already high; shared by the post-reset check
  task automatic test_cold_start(input string tag);
    reset = 1'b0;
    tick(4);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL %s_off_edge4 state got=%0d exp=0", tag, state_o); end
    tick(1);
    total++; if (state_o !== 2'd1 || hpd_out !== 1'b0) begin bad++; $display("FAIL %s_wait_edge5 state=%0d hpd=%0b exp state=1 hpd=0", tag, state_o, hpd_out); end
    tick(7);
    total++; if (state_o !== 2'd1 || hpd_out !== 1'b0) begin bad++; $display("FAIL %s_wait_edge12 state=%0d hpd=%0b exp state=1 hpd=0", tag, state_o, hpd_out); end
    tick(1);
    total++; if (state_o !== 2'd2 || hpd_out !== 1'b1) begin bad++; $display("FAIL %s_on_edge13 state=%0d hpd=%0b exp state=2 hpd=1", tag, state_o, hpd_out); end
    total++; if (replug_count !== 8'd0) begin bad++; $display("FAIL %s_replug got=%0d exp=0", tag, replug_count); end
  endtask

  task automatic test_glitch;
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(5);
    total++; if (state_o !== 2'd2 || hpd_out !== 1'b1) begin bad++; $display("FAIL glitch3_ignored state=%0d hpd=%0b exp state=2 hpd=1", state_o, hpd_out); end
    enable = 1'b0;
    tick(4);
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL glitch4_edge4 state got=%0d exp=2", state_o); end
    tick(1);
    total++; if (state_o !== 2'd0 || hpd_out !== 1'b0) begin bad++; $display("FAIL glitch4_off state=%0d hpd=%0b exp state=0 hpd=0", state_o, hpd_out); end
    enable = 1'b1;
    tick(5);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL reenable_wait state got=%0d exp=1", state_o); end
    tick(8);
    total++; if (state_o !== 2'd2 || hpd_out !== 1'b1) begin bad++; $display("FAIL reenable_on state=%0d hpd=%0b exp state=2 hpd=1", state_o, hpd_out); end
  endtask

  task automatic test_edid_replug;
    edid_update = 1'b1;
    tick(1);
    edid_update = 1'b0;
    total++; if (state_o !== 2'd3 || hpd_out !== 1'b0) begin bad++; $display("FAIL edid_low_entry state=%0d hpd=%0b exp state=3 hpd=0", state_o, hpd_out); end
    total++; if (replug_count !== 8'd1) begin bad++; $display("FAIL edid_replug got=%0d exp=1", replug_count); end
    tick(4);
    edid_update = 1'b1;
    tick(1);
    edid_update = 1'b0;
    total++; if (state_o !== 2'd3 || replug_count !== 8'd1) begin bad++; $display("FAIL edid_in_low state=%0d replug=%0d exp state=3 replug=1", state_o, replug_count); end
    tick(10);
    total++; if (state_o !== 2'd3 || hpd_out !== 1'b0) begin bad++; $display("FAIL edid_low_cycle16 state=%0d hpd=%0b exp state=3 hpd=0", state_o, hpd_out); end
    tick(1);
    total++; if (state_o !== 2'd1 || hpd_out !== 1'b0) begin bad++; $display("FAIL edid_low_expire state=%0d hpd=%0b exp state=1 hpd=0", state_o, hpd_out); end
    edid_update = 1'b1;
    tick(1);
    edid_update = 1'b0;
    tick(6);
    total++; if (state_o !== 2'd1 || hpd_out !== 1'b0) begin bad++; $display("FAIL edid_rewait state=%0d hpd=%0b exp state=1 hpd=0", state_o, hpd_out); end
    tick(1);
    total++; if (state_o !== 2'd2 || hpd_out !== 1'b1) begin bad++; $display("FAIL edid_reassert state=%0d hpd=%0b exp state=2 hpd=1", state_o, hpd_out); end
    tick(3);
    total++; if (state_o !== 2'd2 || replug_count !== 8'd1) begin bad++; $display("FAIL edid_not_queued state=%0d replug=%0d exp state=2 replug=1", state_o, replug_count); end
  endtask

  task automatic test_lock_loss;
    pll_locked = 1'b0;
    tick(2);
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL lock_edge2 state got=%0d exp=2", state_o); end
    tick(1);
    total++; if (state_o !== 2'd3 || replug_count !== 8'd2) begin bad++; $display("FAIL lock_low_entry state=%0d replug=%0d exp state=3 replug=2", state_o, replug_count); end
    tick(15);
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL lock_low_hold state got=%0d exp=3", state_o); end
    tick(1);
    total++; if (state_o !== 2'd1 || hpd_out !== 1'b0) begin bad++; $display("FAIL lock_low_expire state=%0d hpd=%0b exp state=1 hpd=0", state_o, hpd_out); end
    tick(20);
    total++; if (state_o !== 2'd1 || hpd_out !== 1'b0) begin bad++; $display("FAIL lock_absent_hold state=%0d hpd=%0b exp state=1 hpd=0", state_o, hpd_out); end
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(10);
    total++; if (state_o !== 2'd1 || hpd_out !== 1'b0) begin bad++; $display("FAIL short_relock state=%0d hpd=%0b exp state=1 hpd=0", state_o, hpd_out); end
    pll_locked = 1'b1;
    tick(9);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL timer_restart_early state got=%0d exp=1", state_o); end
    tick(1);
    total++; if (state_o !== 2'd2 || hpd_out !== 1'b1) begin bad++; $display("FAIL timer_restart_on state=%0d hpd=%0b exp state=2 hpd=1", state_o, hpd_out); end
  endtask

  task automatic test_simultaneous;
    pll_locked = 1'b0;
    tick(2);
    edid_update = 1'b1;
    tick(1);
    edid_update = 1'b0;
    total++; if (state_o !== 2'd3 || replug_count !== 8'd3) begin bad++; $display("FAIL simul_entry state=%0d replug=%0d exp state=3 replug=3", state_o, replug_count); end
    pll_locked = 1'b1;
    tick(16);
    total++; if (state_o !== 2'd1 || replug_count !== 8'd3) begin bad++; $display("FAIL simul_expire state=%0d replug=%0d exp state=1 replug=3", state_o, replug_count); end
    tick(8);
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL simul_reassert state got=%0d exp=2", state_o); end
  endtask

  task automatic test_saturation;
    int exp_cnt;
    exp_cnt = 3;
    for (int i = 0; i < 300; i++) begin
      edid_update = 1'b1;
      tick(1);
      edid_update = 1'b0;
      if (exp_cnt != 255) exp_cnt++;
      total++; if (replug_count !== 8'(exp_cnt) || state_o !== 2'd3) begin bad++; $display("FAIL sat_iter%0d replug=%0d state=%0d exp replug=%0d state=3", i, replug_count, state_o, exp_cnt); end
      tick(24);
    end
    total++; if (replug_count !== 8'd255 || state_o !== 2'd2) begin bad++; $display("FAIL sat_final replug=%0d state=%0d exp replug=255 state=2", replug_count, state_o); end
  endtask

  task automatic test_reset_mid_low;
    edid_update = 1'b1;
    tick(1);
    edid_update = 1'b0;
    tick(5);
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL midlow_pre state got=%0d exp=3", state_o); end
    reset = 1'b1;
    tick(1);
    total++; if (state_o !== 2'd0 || hpd_out !== 1'b0 || replug_count !== 8'd0) begin bad++; $display("FAIL midlow_reset state=%0d hpd=%0b replug=%0d exp 0 0 0", state_o, hpd_out, replug_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_start("cold");
    test_glitch();
    test_edid_replug();
    test_lock_loss();
    test_simultaneous();
    test_saturation();
    test_reset_mid_low();
    test_cold_start("post_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpd_ctrl.md
Name: hpd_ctrl

Overview:
- Hot-plug-detect controller for the HDMI sink port on the Zybo Z7-20 HDMI pipeline.
- Consumes the static 1-bit enable produced by the constant block upstream, the pixel-clock PLL lock, and an EDID-update request. Drives the HPD pin through an IOBUF.
- Replaces a hard-tied HPD: HPD asserts only once the enable is stable and the clock is locked. Every re-plug pulse meets the HDMI minimum low time.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive cycles `enable` must hold a new value before it is accepted; legal range ≥ 2.
- ASSERT_DELAY, 100000: cycles of continuous synchronized lock required in S_WAIT before HPD rises; ≥ 1.
- HPD_LOW_CYCLES, 10000000: exact HPD low time during a forced re-plug (100 ms at 100 MHz); ≥ 1.
- CNT_W, 24: width of the internal timers; must hold max(DEBOUNCE_CYCLES, ASSERT_DELAY, HPD_LOW_CYCLES).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  HPD enable from the constant block; treated as quasi-static and debounced
- pll_locked  input  1  pixel PLL lock; asynchronous to clk
- edid_update  input  1  single-cycle request to force a re-plug; synchronous to clk
- hpd_out  output  1  hot-plug-detect drive, registered
- state_o  output  2  current FSM state (0 OFF, 1 WAIT, 2 ON, 3 LOW)
- replug_count  output  8  saturating count of entries into S_LOW

Behaviour:
- Reset (sync, active-high) has priority over all other logic. Reset values:
  - hpd_out=0, state_o=0, replug_count=0
  - lock synchronizer flops=0, en_stable=0, all timers=0
- Reset mid-operation, including during S_LOW, drops HPD on the next edge. The LOW pulse is not completed.
- Lock sync: 2-FF synchronizer produces lock_s, giving 2 cycles of latency.
- Debounce:
  - The debounce counter increments while enable != en_stable and clears while they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with inputs still differing, en_stable takes enable and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
- FSM, one transition per clock:
  - S_OFF: hpd_out=0. en_stable=1 → S_WAIT.
  - S_WAIT: hpd_out=0.
    - en_stable=0 → S_OFF.
    - While lock_s=1, the timer increments. lock_s=0 clears the timer.
    - Timer == ASSERT_DELAY-1 with lock_s=1 → S_ON.
  - S_ON: hpd_out=1.
    - Priority: en_stable=0 → S_OFF; else (lock_s=0 or edid_update=1) → S_LOW.
  - S_LOW: hpd_out=0 for exactly HPD_LOW_CYCLES cycles, regardless of lock or edid_update.
    - At expiry: → S_WAIT if en_stable=1, else → S_OFF.
    - en_stable falling during S_LOW does not shorten the pulse.
- hpd_out is a registered decode of the next state, so it changes on the same edge that state_o changes.
- edid_update outside S_ON is ignored, not queued.
- Simultaneous lock loss and edid_update in S_ON produce a single S_LOW entry; replug_count increments once.
- replug_count increments on every S_ON → S_LOW transition and saturates at 255.
- HPD rise latency from lock: the first lock_s=1 cycle in S_WAIT is counted as timer=0. hpd_out rises ASSERT_DELAY cycles after that first lock_s=1 sample.
- No combinational paths from input to output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, ASSERT_DELAY=8, HPD_LOW_CYCLES=16.
- Cold start:
  - Stimulus: enable=1, pll_locked=1 from reset release.
  - Required: en_stable rises at cycle 4 and state_o=1; hpd_out=1 exactly ASSERT_DELAY=8 cycles after the first lock_s=1 sample in S_WAIT; replug_count=0.
- Glitch rejection:
  - Stimulus: while in S_ON, drop enable for 3 cycles.
  - Required: hpd_out stays 1, state_o stays 2.
  - Stimulus: drop enable for 4 cycles.
  - Required: state_o=0, hpd_out=0.
- EDID re-plug:
  - Stimulus: 1-cycle edid_update pulse in S_ON.
  - Required: hpd_out low for exactly 16 cycles, then state_o=1; hpd_out=1 again 8 cycles later; replug_count=1.
- Lock loss:
  - Stimulus: deassert pll_locked in S_ON.
  - Required: S_LOW entered 3 edges later; after 16 low cycles state_o=1, with hpd_out held low while lock is absent.
  - Stimulus: relock for only 5 cycles, then drop lock again.
  - Required: no assertion; the timer restarts.
- Simultaneous events and saturation:
  - Stimulus: edid_update on the same cycle lock_s falls.
  - Required: replug_count increments by exactly 1.
  - Stimulus: 300 forced re-plugs.
  - Required: replug_count=255.
- Reset mid-LOW:
  - Stimulus: assert reset 5 cycles into S_LOW.
  - Required: next edge gives state_o=0, hpd_out=0, replug_count=0; normal cold-start sequence follows reset release.
